// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared widths, load funct3 encodings and FSM states for the writeback unit
package writeback_unit_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_LEN = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// rtl/writeback_unit_load_extend.sv - little-endian lane select, sign/zero extension and misalignment detect
module load_extend
  import writeback_unit_pkg::*;
(
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] ext_data,
  output logic            misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = mem_rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = mem_rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ext_data   = mem_rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  ext_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU: ext_data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH: begin
        ext_data   = {{(XLEN-16){half_lane[15]}}, half_lane};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        ext_data   = {{(XLEN-16){1'b0}}, half_lane};
        misaligned = addr_lo[0];
      end
      // LW and the undefined encodings all take the full word
      default: begin
        ext_data   = mem_rdata;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - merges ALU results and load responses onto the register file write port (option WB_FWD_EN)
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [REG_ADDR_LEN-1:0] alu_rd,
  input  logic [XLEN-1:0]         alu_result,
  output logic                    stall,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [REG_ADDR_LEN-1:0] ld_rd,
  input  logic [2:0]              ld_funct3,
  input  logic [1:0]              ld_addr_lo,
  input  logic                    mem_rvalid,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic                    ld_pending,
  output logic [REG_ADDR_LEN-1:0] ld_pending_rd,
  output logic                    ld_misaligned,
`ifdef WB_FWD_EN
  output logic                    fwd_valid,
  output logic [REG_ADDR_LEN-1:0] fwd_rd,
  output logic [XLEN-1:0]         fwd_data,
`endif
  output logic                    wb_we,
  output logic [REG_ADDR_LEN-1:0] wb_wa,
  output logic [XLEN-1:0]         wb_wdata
);

  wb_state_t state, state_nxt;

  logic [REG_ADDR_LEN-1:0] ld_rd_q;
  logic [2:0]              ld_funct3_q;
  logic [1:0]              ld_addr_lo_q;
  logic [XLEN-1:0]         ld_buf_data;
  logic                    ld_buf_mis;
  logic [XLEN-1:0]         ext_data;
  logic                    ext_mis;

  logic                    skid_full;
  logic [REG_ADDR_LEN-1:0] skid_rd;
  logic [XLEN-1:0]         skid_data;
  logic                    skid_load;
  logic                    skid_drain;

  logic                    sel_we;
  logic [REG_ADDR_LEN-1:0] sel_wa;
  logic [XLEN-1:0]         sel_wdata;

  load_extend u_load_extend (
    .mem_rdata  (mem_rdata),
    .funct3     (ld_funct3_q),
    .addr_lo    (ld_addr_lo_q),
    .ext_data   (ext_data),
    .misaligned (ext_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= WB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    case (state)
      WB_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = WB_WAIT_MEM;
      end
      WB_WAIT_MEM: if (mem_rvalid) state_nxt = WB_WRITE;
      WB_WRITE:    state_nxt = WB_IDLE;
      default:     state_nxt = WB_IDLE;
    endcase
  end

  assign ld_pending    = (state != WB_IDLE);
  assign ld_pending_rd = ld_rd_q;
  assign ld_misaligned = (state == WB_WRITE) && ld_buf_mis;
  assign stall         = skid_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rd_q      <= '0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
      ld_buf_data  <= '0;
      ld_buf_mis   <= 1'b0;
    end else begin
      if (state == WB_IDLE && ld_valid) begin
        ld_rd_q      <= ld_rd;
        ld_funct3_q  <= ld_funct3;
        ld_addr_lo_q <= ld_addr_lo;
      end
      if (state == WB_WAIT_MEM && mem_rvalid) begin
        ld_buf_data <= ext_data;
        ld_buf_mis  <= ext_mis;
      end
    end
  end

  // Load writeback owns the port in WRITE; a colliding ALU result parks in the skid
  always_comb begin
    sel_we     = 1'b0;
    sel_wa     = wb_wa;
    sel_wdata  = wb_wdata;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (state == WB_WRITE) begin
      sel_we    = !ld_buf_mis && (ld_rd_q != '0);
      sel_wa    = ld_rd_q;
      sel_wdata = ld_buf_data;
      skid_load = alu_valid && !skid_full;
    end else if (skid_full) begin
      sel_we     = (skid_rd != '0);
      sel_wa     = skid_rd;
      sel_wdata  = skid_data;
      skid_drain = 1'b1;
    end else if (alu_valid) begin
      sel_we    = (alu_rd != '0);
      sel_wa    = alu_rd;
      sel_wdata = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_full <= 1'b0;
      skid_rd   <= '0;
      skid_data <= '0;
    end else if (skid_load) begin
      skid_full <= 1'b1;
      skid_rd   <= alu_rd;
      skid_data <= alu_result;
    end else if (skid_drain) begin
      skid_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we    <= 1'b0;
      wb_wa    <= '0;
      wb_wdata <= '0;
    end else begin
      wb_we    <= sel_we;
      wb_wa    <= sel_wa;
      wb_wdata <= sel_wdata;
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = sel_we;
  assign fwd_rd    = sel_wa;
  assign fwd_data  = sel_wdata;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit with a write-port scoreboard
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ld_pending;
  logic [4:0]  ld_pending_rd;
  logic        ld_misaligned;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wdata;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_result    (alu_result),
    .stall         (stall),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_rd         (ld_rd),
    .ld_funct3     (ld_funct3),
    .ld_addr_lo    (ld_addr_lo),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .ld_pending    (ld_pending),
    .ld_pending_rd (ld_pending_rd),
    .ld_misaligned (ld_misaligned),
`ifdef WB_FWD_EN
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
`endif
    .wb_we         (wb_we),
    .wb_wa         (wb_wa),
    .wb_wdata      (wb_wdata)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_mis;
  } ld_vec_t;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] d;
  } wr_t;

  ld_vec_t vecs[15];
  wr_t     sb[$];
  wr_t     mon_w;
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] wa, input logic [31:0] d);
    wr_t w;
    w.wa = wa;
    w.d  = d;
    sb.push_back(w);
  endtask

  always @(negedge clk) begin
    if (!reset && wb_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x%0d=0x%08h expected no write", wb_wa, wb_wdata);
      end else begin
        mon_w = sb.pop_front();
        if (wb_wa !== mon_w.wa || wb_wdata !== mon_w.d) begin
          errors++;
          $display("FAIL sb_write: got x%0d=0x%08h expected x%0d=0x%08h",
                   wb_wa, wb_wdata, mon_w.wa, mon_w.d);
        end
      end
    end
  end

  task automatic do_load(input int idx, input ld_vec_t v, input int delay);
    chk($sformatf("v%0d_ld_ready", idx), ld_ready, 1);
    ld_valid = 1'b1; ld_rd = v.rd; ld_funct3 = v.f3; ld_addr_lo = v.lo;
    tick();
    ld_valid = 1'b0;
    chk($sformatf("v%0d_pending_rd", idx), ld_pending_rd, v.rd);
    for (int k = 0; k < delay; k++) begin
      chk($sformatf("v%0d_pending_wait", idx), ld_pending, 1);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = v.rdata;
    if (v.exp_we) push(v.rd, v.exp_data);
    tick();
    mem_rvalid = 1'b0;
    chk($sformatf("v%0d_misaligned", idx), ld_misaligned, v.exp_mis);
    tick();
    chk($sformatf("v%0d_wb_we", idx), wb_we, v.exp_we);
    if (v.exp_we) chk($sformatf("v%0d_wb_wdata", idx), wb_wdata, v.exp_data);
    chk($sformatf("v%0d_pending_clear", idx), ld_pending, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'd7,  3'b000, 2'd2, 32'h0080FF00, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[1]  = '{5'd7,  3'b100, 2'd2, 32'h0080FF00, 1'b1, 32'h00000080, 1'b0};
    vecs[2]  = '{5'd8,  3'b001, 2'd2, 32'h80011234, 1'b1, 32'hFFFF8001, 1'b0};
    vecs[3]  = '{5'd8,  3'b101, 2'd2, 32'h80011234, 1'b1, 32'h00008001, 1'b0};
    vecs[4]  = '{5'd8,  3'b001, 2'd0, 32'h80011234, 1'b1, 32'h00001234, 1'b0};
    vecs[5]  = '{5'd9,  3'b010, 2'd0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{5'd9,  3'b011, 2'd0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[7]  = '{5'd20, 3'b110, 2'd0, 32'h8000_0001, 1'b1, 32'h80000001, 1'b0};
    vecs[8]  = '{5'd21, 3'b000, 2'd3, 32'h80000000, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[9]  = '{5'd13, 3'b000, 2'd1, 32'h00007F00, 1'b1, 32'h0000007F, 1'b0};
    vecs[10] = '{5'd14, 3'b001, 2'd1, 32'h11223344, 1'b0, 32'h00000000, 1'b1};
    vecs[11] = '{5'd14, 3'b010, 2'd1, 32'h11223344, 1'b0, 32'h00000000, 1'b1};
    vecs[12] = '{5'd14, 3'b010, 2'd2, 32'h11223344, 1'b0, 32'h00000000, 1'b1};
    vecs[13] = '{5'd14, 3'b101, 2'd3, 32'h11223344, 1'b0, 32'h00000000, 1'b1};
    vecs[14] = '{5'd0,  3'b010, 2'd0, 32'h55555555, 1'b0, 32'h00000000, 1'b0};

    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_wa", wb_wa, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pending", ld_pending, 0);
    chk("rst_pending_rd", ld_pending_rd, 0);
    chk("rst_misaligned", ld_misaligned, 0);
    chk("rst_ld_ready", ld_ready, 1);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) do_load(i, vecs[i], (i == 0) ? 3 : i % 4);

    // ALU path, then the same to x0
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h1234; push(5'd5, 32'h1234);
    tick();
    alu_valid = 1'b0;
    chk("alu_we", wb_we, 1);
    chk("alu_wa", wb_wa, 5);
    chk("alu_wdata", wb_wdata, 32'h1234);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'h9999;
    tick();
    alu_valid = 1'b0;
    chk("alu_x0_we", wb_we, 0);

    // ALU collides with the WRITE cycle of a load
    ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    tick();
    ld_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55; push(5'd4, 32'h55);
    tick();
    mem_rvalid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'hAA; push(5'd3, 32'hAA);
    chk("col_stall_pre", stall, 0);
    tick();
    alu_rd = 5'd6; alu_result = 32'h66;
    chk("col_load_we", wb_we, 1);
    chk("col_load_wa", wb_wa, 4);
    chk("col_stall", stall, 1);
    tick();
    alu_valid = 1'b0;
    chk("col_skid_wa", wb_wa, 3);
    chk("col_skid_wdata", wb_wdata, 32'hAA);
    chk("col_stall_clear", stall, 0);
    tick();
    chk("col_idle_we", wb_we, 0);

    // Misaligned load with a skidded ALU result
    ld_valid = 1'b1; ld_rd = 5'd10; ld_funct3 = 3'b010; ld_addr_lo = 2'd1;
    tick();
    ld_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("mis_pulse", ld_misaligned, 1);
    alu_valid = 1'b1; alu_rd = 5'd11; alu_result = 32'h11; push(5'd11, 32'h11);
    tick();
    alu_valid = 1'b0;
    chk("mis_no_write", wb_we, 0);
    chk("mis_pulse_end", ld_misaligned, 0);
    chk("mis_pending", ld_pending, 0);
    chk("mis_stall", stall, 1);
    tick();
    chk("mis_drain_wa", wb_wa, 11);

    // Hazard export with a simultaneous ALU result
    ld_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'h22; push(5'd2, 32'h22);
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    chk("hz_alu_wa", wb_wa, 2);
    chk("hz_ld_ready", ld_ready, 0);
    for (int k = 0; k < 2; k++) begin
      chk("hz_pending", ld_pending, 1);
      chk("hz_pending_rd", ld_pending_rd, 9);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h99; push(5'd9, 32'h99);
    tick();
    mem_rvalid = 1'b0;
    chk("hz_pending_write", ld_pending, 1);
    tick();
    chk("hz_pending_done", ld_pending, 0);
    chk("hz_load_wa", wb_wa, 9);
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_pending", ld_pending, 0);
    tick();
    chk("idle_rvalid_we", wb_we, 0);

    // Reset abandons an outstanding load
    ld_valid = 1'b1; ld_rd = 5'd12; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    tick();
    ld_valid = 1'b0;
    chk("rw_pending", ld_pending, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    chk("rw_ld_ready", ld_ready, 1);
    chk("rw_pending_clear", ld_pending, 0);
    tick();
    mem_rvalid = 1'b0;
    chk("rw_still_idle", ld_pending, 0);
    tick();
    chk("rw_no_write", wb_we, 0);
    tick();
    chk("rw_no_write2", wb_we, 0);

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
